seg7_scan_driver: RTL

//  Time-multiplexed driver for the board's 4-digit common-anode 7-segment display. Consumes the four
//  per-digit segment codes from the stopwatch counter (one, ten, hundred, thd; {g,f,e,d,c,b,a}, active-high).

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_scan_timer.sv | 37 +++
 rtl/seg7_scan_driver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
package seg7_pkg;

  // Segment code {g,f,e,d,c,b,a}, active-high
  typedef logic [6:0] seg_t;

  // Code for a displayed '0', used by leading-zero blanking
  localparam seg_t SEG_ZERO = 7'b0111111;

  // Digit positions on the display, also the scan index values
  localparam logic [1:0] DIGIT_UNITS    = 2'd0;
  localparam logic [1:0] DIGIT_TENS     = 2'd1;
  localparam logic [1:0] DIGIT_HUNDREDS = 2'd2;
  localparam logic [1:0] DIGIT_THD      = 2'd3;

  // Active-high one-hot anode pattern for a digit index
  function automatic logic [3:0] digit_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot counter and digit rotation for the scan driver; flags the frame snapshot point.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       idx,
  output logic             snap,
  output logic             frame_tick
);

  logic wrap;

  assign wrap = (cnt == CNT_W'(SCAN_DIV - 1));
  // Last cycle of the last digit slot: the frame boundary
  assign snap = wrap && (idx == DIGIT_THD);

  // Slot counter, digit index and the registered frame pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= DIGIT_UNITS;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        idx <= idx + 2'd1;
      end
      frame_tick <= snap;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with ghost blanking,
// brightness PWM, leading-zero suppression and per-frame input snapshots.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int GHOST          = 16,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       lz_blank,
  input  logic [3:0] brightness,
  input  logic [3:0] dp_mask,
  input  logic [6:0] one,
  input  logic [6:0] ten,
  input  logic [6:0] hundred,
  input  logic [6:0] thd,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  // Wide enough for (SCAN_DIV-GHOST)*16 without overflow
  localparam int OT_W  = CNT_W + 5;

  localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam seg_t       SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             snap;

  seg7_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .cnt        (cnt),
    .idx        (idx),
    .snap       (snap),
    .frame_tick (frame_tick)
  );

  seg_t digit_in [4];
  assign digit_in[DIGIT_UNITS]    = one;
  assign digit_in[DIGIT_TENS]     = ten;
  assign digit_in[DIGIT_HUNDREDS] = hundred;
  assign digit_in[DIGIT_THD]      = thd;

  seg_t       shadow_reg [4];
  logic [3:0] dp_mask_reg;
  logic       lz_blank_reg;

  // Frame snapshot: displayed data only changes at a frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) shadow_reg[i] <= '0;
      dp_mask_reg  <= '0;
      lz_blank_reg <= 1'b0;
    end else if (snap) begin
      for (int i = 0; i < 4; i++) shadow_reg[i] <= digit_in[i];
      dp_mask_reg  <= dp_mask;
      lz_blank_reg <= lz_blank;
    end
  end

  logic [3:0] blank;

  // Leading-zero chain from the thousands digit down; units is always shown
  always_comb begin
    blank    = '0;
    blank[3] = lz_blank_reg && (shadow_reg[3] == SEG_ZERO);
    blank[2] = blank[3] && (shadow_reg[2] == SEG_ZERO);
    blank[1] = blank[2] && (shadow_reg[1] == SEG_ZERO);
  end

  logic [OT_W-1:0] span;
  logic [OT_W-1:0] prod;
  logic [OT_W-1:0] on_time_raw;
  logic [OT_W-1:0] on_time;
  logic [OT_W-1:0] cnt_ext;
  logic            lit;

  // PWM window: (usable slot length) * (brightness+1) / 16, at least one cycle
  assign span        = OT_W'(SCAN_DIV - GHOST);
  assign prod        = span * ({{(OT_W-4){1'b0}}, brightness} + OT_W'(1));
  assign on_time_raw = prod >> 4;
  assign on_time     = (on_time_raw == '0) ? OT_W'(1) : on_time_raw;
  assign cnt_ext     = OT_W'(cnt);
  assign lit         = en && (cnt_ext >= OT_W'(GHOST))
                       && ((cnt_ext - OT_W'(GHOST)) < on_time) && !blank[idx];

  logic [3:0] an_next;
  seg_t       seg_next;
  logic       dp_next;

  // Output selection with polarity applied last
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = DP_OFF;
    if (lit) begin
      an_next  = (AN_ACTIVE_LOW != 0) ? ~digit_onehot(idx) : digit_onehot(idx);
      seg_next = (SEG_ACTIVE_LOW != 0) ? ~shadow_reg[idx] : shadow_reg[idx];
      dp_next  = (SEG_ACTIVE_LOW != 0) ? ~dp_mask_reg[idx] : dp_mask_reg[idx];
    end
  end

  // Output registers, inactive during reset
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule
